// File: rtl/core_bus_arb_pkg.sv
// Shared types and widths for the core bus arbiter that sits between the
// instruction-fetch requester, the memory access unit and the pipelined memory bus.
package core_bus_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MAU  = 2'd2
    } bus_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_IF  = 2'd1,
        ARB_GNT_MAU = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_t;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;

endpackage

// File: rtl/core_bus_outst.sv
// Outstanding-transfer counter: +1 per accepted strobe, -1 per ack, saturating at
// OUTST_MAX; an ack with nothing outstanding is dropped and raises a sticky error.
module core_bus_outst #(
    parameter int unsigned OUTST_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    input  logic err_mask,
    output logic full,
    output logic empty,
    output logic err
);

    localparam int unsigned CW = $clog2(OUTST_MAX + 1);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          do_up, do_down;

    assign full  = (count_q == CW'(OUTST_MAX));
    assign empty = (count_q == '0);

    assign do_up   = up & ~full;
    assign do_down = down & ~empty;

    always_comb begin
        count_d = count_q;
        if (do_up && !do_down) begin
            count_d = count_q + CW'(1);
        end else if (do_down && !do_up) begin
            count_d = count_q - CW'(1);
        end
        // Acks that trail a reset are expected and must not flag an error.
        err_d = err_q | (down & empty & ~err_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/core_bus_arb.sv
// Arbitrates the single pipelined memory bus between instruction fetch and the MAU:
// one owner per bus tenure, MAU priority with an IF starvation guard, ack/data routed to owner.
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter int unsigned OUTST_MAX     = 4,
    parameter int unsigned MAU_BURST_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_cyc,
    input  logic             if_stb,
    input  logic             if_we,
    input  logic [ADR_W-1:0] if_adr,
    input  logic [DAT_W-1:0] if_dat_ms,
    output logic             if_ack,
    output logic             if_stall,
    output logic [DAT_W-1:0] if_dat_so,
    input  logic             mau_cyc,
    input  logic             mau_stb,
    input  logic             mau_we,
    input  logic [ADR_W-1:0] mau_adr,
    input  logic [DAT_W-1:0] mau_dat_ms,
    output logic             mau_ack,
    output logic             mau_stall,
    output logic [DAT_W-1:0] mau_dat_so,
    output logic             mem_cyc,
    output logic             mem_stb,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [DAT_W-1:0] mem_dat_ms,
    input  logic             mem_ack,
    input  logic             mem_stall,
    input  logic [DAT_W-1:0] mem_dat_so,
    output logic [1:0]       owner,
    output logic             arb_err
);

    localparam int unsigned BW = $clog2(MAU_BURST_MAX + 1);

    arb_state_t    state_q, state_d, decide;
    bus_owner_t    owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          drop_q;

    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;
    logic             granted, accept, ack_ok, starve, full, empty, err;

    core_bus_outst #(
        .OUTST_MAX(OUTST_MAX)
    ) u_outst (
        .clk     (clk),
        .rst     (rst),
        .up      (accept),
        .down    (mem_ack),
        .err_mask(drop_q),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        case (owner_q)
            OWN_IF: begin
                own_cyc = if_cyc;
                own_stb = if_stb;
                own_we  = if_we;
                own_adr = if_adr;
                own_dat = if_dat_ms;
            end
            OWN_MAU: begin
                own_cyc = mau_cyc;
                own_stb = mau_stb;
                own_we  = mau_we;
                own_adr = mau_adr;
                own_dat = mau_dat_ms;
            end
            default: ;
        endcase
    end

    assign granted = (state_q == ARB_GNT_IF) || (state_q == ARB_GNT_MAU);
    assign starve  = (burst_q == BW'(MAU_BURST_MAX));

    // MAU wins every decision unless IF is waiting and has been passed over too often.
    always_comb begin
        decide = ARB_IDLE;
        if (mau_cyc && !(if_cyc && starve)) begin
            decide = ARB_GNT_MAU;
        end else if (if_cyc) begin
            decide = ARB_GNT_IF;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:                state_d = decide;
            ARB_GNT_IF, ARB_GNT_MAU: if (!own_cyc) state_d = empty ? decide : ARB_DRAIN;
            ARB_DRAIN:               if (empty) state_d = decide;
            default:                 state_d = ARB_IDLE;
        endcase

        case (state_d)
            ARB_GNT_IF:  owner_d = OWN_IF;
            ARB_GNT_MAU: owner_d = OWN_MAU;
            ARB_DRAIN:   owner_d = owner_q;
            default:     owner_d = OWN_NONE;
        endcase

        burst_d = burst_q;
        if (state_d == ARB_GNT_IF && state_q != ARB_GNT_IF) begin
            burst_d = '0;
        end else if (state_d == ARB_GNT_MAU && state_q != ARB_GNT_MAU && if_cyc && !starve) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            burst_q <= '0;
            drop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            if (mem_cyc) drop_q <= 1'b0;
        end
    end

    assign mem_cyc    = (state_q != ARB_IDLE);
    assign mem_stb    = granted & own_cyc & own_stb & ~full;
    assign mem_we     = granted & own_we;
    assign mem_adr    = own_adr;
    assign mem_dat_ms = own_dat;
    assign accept     = mem_stb & ~mem_stall;
    assign ack_ok     = mem_ack & ~empty;

    assign if_ack     = ack_ok & (owner_q == OWN_IF);
    assign mau_ack    = ack_ok & (owner_q == OWN_MAU);
    assign if_dat_so  = (owner_q == OWN_IF) ? mem_dat_so : '0;
    assign mau_dat_so = (owner_q == OWN_MAU) ? mem_dat_so : '0;
    assign if_stall   = (state_q != ARB_GNT_IF) | mem_stall | full;
    assign mau_stall  = (state_q != ARB_GNT_MAU) | mem_stall | full;

    assign owner   = owner_q;
    assign arb_err = err;

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed scenarios for arbitration, outstanding limit, drain, starvation and reset,
// followed by randomized traffic scored against an in-order memory transaction queue.
module tb_core_bus_arb;
    import core_bus_arb_pkg::*;

    localparam int unsigned OMAX = 4;
    localparam int unsigned BMAX = 8;
    localparam logic [31:0] KEY  = 32'h5A5A_0F0F;

    logic        clk, rst;
    logic        if_cyc, if_stb, if_we, if_ack, if_stall;
    logic [31:0] if_adr, if_dat_ms, if_dat_so;
    logic        mau_cyc, mau_stb, mau_we, mau_ack, mau_stall;
    logic [31:0] mau_adr, mau_dat_ms, mau_dat_so;
    logic        mem_cyc, mem_stb, mem_we, mem_ack, mem_stall;
    logic [31:0] mem_adr, mem_dat_ms, mem_dat_so;
    logic [1:0]  owner;
    logic        arb_err;

    core_bus_arb #(
        .OUTST_MAX    (OMAX),
        .MAU_BURST_MAX(BMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_cyc    (if_cyc),
        .if_stb    (if_stb),
        .if_we     (if_we),
        .if_adr    (if_adr),
        .if_dat_ms (if_dat_ms),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .if_dat_so (if_dat_so),
        .mau_cyc   (mau_cyc),
        .mau_stb   (mau_stb),
        .mau_we    (mau_we),
        .mau_adr   (mau_adr),
        .mau_dat_ms(mau_dat_ms),
        .mau_ack   (mau_ack),
        .mau_stall (mau_stall),
        .mau_dat_so(mau_dat_so),
        .mem_cyc   (mem_cyc),
        .mem_stb   (mem_stb),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_dat_ms(mem_dat_ms),
        .mem_ack   (mem_ack),
        .mem_stall (mem_stall),
        .mem_dat_so(mem_dat_so),
        .owner     (owner),
        .arb_err   (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_if(input logic c, input logic s, input logic [31:0] a);
        if_cyc = c;
        if_stb = s;
        if_adr = a;
    endtask

    task automatic set_mau(input logic c, input logic s, input logic [31:0] a);
        mau_cyc = c;
        mau_stb = s;
        mau_adr = a;
    endtask

    typedef struct packed {
        logic        r;
        logic [31:0] adr;
    } mem_ent_t;

    mem_ent_t    q_mem[$];
    logic        rc[2], rs[2], rw[2];
    logic [31:0] ra[2], rd[2];
    int          rem[2];
    int          burst_m;
    bus_owner_t  exp_own;

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0; mem_stall = 1'b0; mem_dat_so = '0;
        set_if(0, 0, 0); set_mau(0, 0, 0);
        if_we = 0; mau_we = 0; if_dat_ms = '0; mau_dat_ms = '0;
        repeat (3) nxt();
        #1;
        check("rst_owner", owner, OWN_NONE);
        check("rst_mem_cyc", mem_cyc, 0);
        check("rst_mem_stb", mem_stb, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_stall", if_stall, 1);
        check("rst_mau_stall", mau_stall, 1);
        check("rst_acks", {if_ack, mau_ack}, 0);
        check("rst_err", arb_err, 0);
        nxt(); rst = 1'b0;

        // IF alone: one-cycle grant latency, ack two cycles after accept.
        nxt(); set_if(1, 1, 32'h100); #1;
        check("t1_idle_owner", owner, OWN_NONE);
        check("t1_idle_stall", if_stall, 1);
        nxt(); #1;
        check("t1_owner", owner, OWN_IF);
        check("t1_mem_cyc", mem_cyc, 1);
        check("t1_mem_stb", mem_stb, 1);
        check("t1_mem_adr", mem_adr, 32'h100);
        check("t1_if_stall", if_stall, 0);
        check("t1_mau_stall", mau_stall, 1);
        nxt(); set_if(1, 0, 32'h100);
        nxt(); mem_ack = 1; mem_dat_so = 32'hDEAD_BEEF; #1;
        check("t1_if_ack", if_ack, 1);
        check("t1_if_dat", if_dat_so, 32'hDEAD_BEEF);
        check("t1_mau_ack", mau_ack, 0);
        nxt(); mem_ack = 0; set_if(0, 0, 0); #1;
        check("t1_owner_hold", owner, OWN_IF);
        nxt(); #1;
        check("t1_release", owner, OWN_NONE);
        check("t1_mem_cyc_off", mem_cyc, 0);

        // Contention from IDLE: MAU first, then IF with no idle gap.
        nxt(); set_if(1, 0, 0); set_mau(1, 0, 0);
        nxt(); #1;
        check("t2_owner_mau", owner, OWN_MAU);
        check("t2_if_stall", if_stall, 1);
        nxt(); set_mau(0, 0, 0); #1;
        check("t2_owner_mau2", owner, OWN_MAU);
        nxt(); #1;
        check("t2_owner_if", owner, OWN_IF);
        check("t2_mem_cyc", mem_cyc, 1);
        nxt(); set_if(0, 0, 0);
        nxt(); #1;
        check("t2_idle", owner, OWN_NONE);

        // Outstanding limit.
        set_mau(1, 0, 0);
        nxt(); #1;
        check("t3_owner", owner, OWN_MAU);
        for (int k = 0; k < 5; k++) begin
            nxt(); set_mau(1, 1, 32'h200 + 32'(4 * k)); #1;
            check($sformatf("t3_stall%0d", k), mau_stall, (k == 4));
            check($sformatf("t3_stb%0d", k), mem_stb, (k != 4));
        end
        nxt(); #1;
        check("t3_full_hold", mau_stall, 1);
        nxt(); mem_ack = 1; #1;
        check("t3_ack", mau_ack, 1);
        check("t3_ack_stall", mau_stall, 1);
        nxt(); mem_ack = 0; #1;
        check("t3_5th_stall", mau_stall, 0);
        check("t3_5th_stb", mem_stb, 1);
        check("t3_5th_adr", mem_adr, 32'h210);
        nxt(); set_mau(1, 0, 0); mem_ack = 1;
        nxt(); set_mau(1, 1, 32'h214); #1;
        check("t3_both_stall", mau_stall, 0);
        nxt(); set_mau(1, 1, 32'h218); mem_ack = 0; #1;
        check("t3_kept3", mau_stall, 0);
        nxt(); set_mau(1, 1, 32'h21C); #1;
        check("t3_full_again", mau_stall, 1);

        // Drain: leave two outstanding, drop cyc with IF waiting.
        nxt(); set_mau(1, 0, 0); mem_ack = 1;
        nxt();
        nxt(); mem_ack = 0; set_mau(0, 0, 0); set_if(1, 0, 0);
        nxt(); mem_ack = 1; mem_dat_so = 32'h11; #1;
        check("t4_owner", owner, OWN_MAU);
        check("t4_cyc", mem_cyc, 1);
        check("t4_stb", mem_stb, 0);
        check("t4_ack1", mau_ack, 1);
        check("t4_dat1", mau_dat_so, 32'h11);
        check("t4_if_ack", if_ack, 0);
        check("t4_if_stall", if_stall, 1);
        nxt(); mem_dat_so = 32'h22; #1;
        check("t4_ack2", mau_ack, 1);
        check("t4_dat2", mau_dat_so, 32'h22);
        nxt(); mem_ack = 0; #1;
        check("t4_still_mau", owner, OWN_MAU);
        nxt(); #1;
        check("t4_if_gnt", owner, OWN_IF);
        nxt(); set_if(0, 0, 0);
        nxt(); #1;
        check("t4_idle", owner, OWN_NONE);

        // Starvation: MAU re-requests during each drain while IF keeps cyc high.
        burst_m = 0;
        set_if(1, 0, 0); set_mau(1, 0, 0);
        for (int i = 1; i <= BMAX + 1; i++) begin
            if (burst_m == BMAX) begin
                exp_own = OWN_IF; burst_m = 0;
            end else begin
                exp_own = OWN_MAU; burst_m++;
            end
            nxt(); #1;
            check($sformatf("t5_grant%0d", i), owner, exp_own);
            if (exp_own == OWN_MAU) set_mau(1, 1, 32'h400 + 32'(i));
            else set_if(1, 1, 32'h500);
            nxt();
            if (exp_own == OWN_MAU) set_mau(0, 0, 0);
            else set_if(0, 0, 0);
            nxt();
            set_if(1, 0, 0); set_mau(1, 0, 0); mem_ack = 1;
            nxt(); mem_ack = 0;
        end
        nxt(); #1;
        check("t5_cleared", owner, OWN_MAU);
        set_if(0, 0, 0); set_mau(0, 0, 0);
        nxt(); nxt(); #1;
        check("t5_idle", owner, OWN_NONE);

        // Reset mid-tenure with one outstanding, then a late ack.
        set_mau(1, 1, 32'h300);
        nxt(); #1;
        check("t6_owner", owner, OWN_MAU);
        nxt(); set_mau(1, 0, 0); rst = 1;
        nxt(); rst = 0; set_mau(0, 0, 0); mem_ack = 1; #1;
        check("t6_cyc", mem_cyc, 0);
        check("t6_owner_none", owner, OWN_NONE);
        check("t6_no_ack", mau_ack, 0);
        nxt(); mem_ack = 0; #1;
        check("t6_err0", arb_err, 0);
        set_if(1, 0, 0);
        nxt(); set_if(0, 0, 0);
        nxt(); mem_ack = 1; #1;
        check("t6_stray_noack", if_ack, 0);
        nxt(); mem_ack = 0; #1;
        check("t6_err1", arb_err, 1);
        nxt(); #1;
        check("t6_err_sticky", arb_err, 1);
        rst = 1;
        nxt(); rst = 0; #1;
        check("t6_err_rst", arb_err, 0);

        // Randomized traffic against an in-order memory queue.
        for (int r = 0; r < 2; r++) begin
            rc[r] = 0; rs[r] = 0; rw[r] = 0; ra[r] = '0; rd[r] = '0; rem[r] = 0;
        end
        for (int t = 0; t < 3500; t++) begin
            logic     acc[2];
            logic     mem_acc, stop;
            mem_ent_t e;
            int       wsel;
            stop = (t >= 3000);
            nxt();
            mem_stall = ($urandom_range(0, 3) == 0);
            if (q_mem.size() > 0 && $urandom_range(0, 1) == 1) begin
                mem_ack = 1; mem_dat_so = q_mem[0].adr ^ KEY;
            end else begin
                mem_ack = 0; mem_dat_so = $urandom;
            end
            for (int r = 0; r < 2; r++) begin
                if (!rc[r]) begin
                    if (!stop && $urandom_range(0, 7) == 0) begin
                        rc[r] = 1; rem[r] = $urandom_range(1, 6);
                    end
                end else if (!rs[r] && rem[r] == 0 && $urandom_range(0, 1) == 1) begin
                    rc[r] = 0;
                end
                if (rc[r] && !rs[r] && rem[r] > 0 && $urandom_range(0, 1) == 1) begin
                    rs[r] = 1; rem[r]--;
                    ra[r] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    rd[r] = $urandom; rw[r] = 1'($urandom_range(0, 1));
                end
            end
            set_if(rc[0], rs[0], ra[0]); if_we = rw[0]; if_dat_ms = rd[0];
            set_mau(rc[1], rs[1], ra[1]); mau_we = rw[1]; mau_dat_ms = rd[1];
            #1;
            acc[0]  = rs[0] & ~if_stall;
            acc[1]  = rs[1] & ~mau_stall;
            mem_acc = mem_stb & ~mem_stall;
            if (acc[0] || acc[1] || mem_acc) begin
                check("rnd_accept", {acc[1], acc[0]}, mem_acc ? (acc[1] ? 2'b10 : 2'b01) : 2'b00);
                wsel = acc[1] ? 1 : 0;
                check("rnd_adr", mem_adr, ra[wsel]);
                check("rnd_we", mem_we, rw[wsel]);
                check("rnd_dat_ms", mem_dat_ms, rd[wsel]);
                check("rnd_limit", q_mem.size() < OMAX, 1);
            end
            if (q_mem.size() == OMAX) check("rnd_full_stb", mem_stb, 0);
            e = (q_mem.size() > 0) ? q_mem[0] : '0;
            check("rnd_if_ack", if_ack, mem_ack && !e.r);
            check("rnd_mau_ack", mau_ack, mem_ack && e.r);
            if (mem_ack) begin
                check("rnd_dat_so", e.r ? mau_dat_so : if_dat_so, e.adr ^ KEY);
                void'(q_mem.pop_front());
            end
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    q_mem.push_back('{r: 1'(r), adr: ra[r]});
                    rs[r] = 0;
                end
            end
            if (stop && q_mem.size() == 0 && !rc[0] && !rc[1] && owner == OWN_NONE) break;
        end
        mem_ack = 0;
        check("rnd_drained", q_mem.size(), 0);
        check("rnd_idle", owner, OWN_NONE);
        check("rnd_err", arb_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
